// File: rtl/io_port_hub_pkg.sv
// Shared definitions for the I/O port hub: FSM state codes used by the
// input (IDLE/WAIT/DONE) and output (IDLE/SEND/DONE) controllers.
package io_port_hub_pkg;

   typedef logic [1:0] io_state_t;

   localparam io_state_t IO_IDLE = 2'd0;
   localparam io_state_t IO_WAIT = 2'd1;   // input FSM: waiting for device data
   localparam io_state_t IO_SEND = 2'd1;   // output FSM: word offered to device
   localparam io_state_t IO_DONE = 2'd2;

endpackage

// File: rtl/io_port_hub_hold_slot.sv
// One-entry input hold slot for a single device channel. Keeps a word that
// arrives before the processor asks for it and flags words lost by overwrite.
module io_hold_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enter_in,
   input  logic [DATA_W-1:0] din,
   input  logic              consume,
   output logic [DATA_W-1:0] dout,
   output logic              pending,
   output logic              overrun
);

   logic [DATA_W-1:0] r_hold;
   logic              r_pending;
   logic              r_overrun;

   // Capture device words; a read empties the slot and clears its overrun history
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold    <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else if (enter_in) begin
         r_hold    <= din;
         r_pending <= 1'b1;
         if (consume) begin
            r_overrun <= 1'b0;
         end else if (r_pending) begin
            r_overrun <= 1'b1;
         end else begin
            r_overrun <= r_overrun;
         end
      end else if (consume) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_hold    <= r_hold;
         r_pending <= r_pending;
         r_overrun <= r_overrun;
      end
   end

   assign dout    = r_hold;
   assign pending = r_pending;
   assign overrun = r_overrun;

endmodule

// File: rtl/io_port_hub.sv
// I/O controller between the processor datapath and NUM_DEV devices:
// device decode, input FSM with per-device hold slots, output FSM with
// per-device output registers, and a sticky out-of-range flag.
module io_port_hub
   import io_port_hub_pkg::*;
#(
   parameter int NUM_DEV = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         adress,
   input  logic [DATA_W-1:0]         p_data,
   input  logic                      in_req,
   input  logic                      new_out,
   output logic [DATA_W-1:0]         e_data,
   output logic                      in_ready,
   output logic                      out_ready,
   input  logic [NUM_DEV*DATA_W-1:0] dev_in,
   input  logic [NUM_DEV-1:0]        enter_in,
   output logic [NUM_DEV*DATA_W-1:0] dev_out,
   output logic [NUM_DEV-1:0]        enter_out,
   input  logic [NUM_DEV-1:0]        done_out,
   output logic [NUM_DEV-1:0]        pending,
   output logic [NUM_DEV-1:0]        overrun,
   output logic                      addr_err,
   output logic [1:0]                input_state,
   output logic [1:0]                output_state
);

   localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

   function automatic logic [NUM_DEV-1:0] f_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_DEV-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Device decode from the live address (used only while an FSM is idle)
   logic [IDX_W-1:0] w_dev;
   logic             w_in_range;
   assign w_dev      = (NUM_DEV > 1) ? adress[IDX_W-1:0] : '0;
   assign w_in_range = (32'(adress) < 32'(NUM_DEV));

   // Hold slots: a bypassed strobe goes straight to e_data and never lands in the slot
   logic [DATA_W-1:0]  w_slot_dout [NUM_DEV];
   logic [NUM_DEV-1:0] w_consume;
   logic [NUM_DEV-1:0] w_bypass;
   logic [NUM_DEV-1:0] w_slot_enter;
   assign w_slot_enter = enter_in & ~w_bypass;

   for (genvar g = 0; g < NUM_DEV; g++) begin : g_slot
      io_hold_slot #(.DATA_W(DATA_W)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .enter_in (w_slot_enter[g]),
         .din      (dev_in[g*DATA_W +: DATA_W]),
         .consume  (w_consume[g]),
         .dout     (w_slot_dout[g]),
         .pending  (pending[g]),
         .overrun  (overrun[g])
      );
   end

   io_state_t         r_in_state, w_in_next;
   io_state_t         r_out_state, w_out_next;
   logic [IDX_W-1:0]  r_in_dev, r_out_dev;
   logic [DATA_W-1:0] r_e_data, w_in_data;
   logic              w_in_load, w_in_err, w_out_start, w_out_err;
   logic              r_addr_err;
   logic [NUM_DEV*DATA_W-1:0] r_dev_out;
   logic [NUM_DEV-1:0]        r_enter_out;

   // State registers for both FSMs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_state  <= IO_IDLE;
         r_out_state <= IO_IDLE;
      end else begin
         r_in_state  <= w_in_next;
         r_out_state <= w_out_next;
      end
   end

   // Input FSM next state: slot hit, same-cycle bypass, or wait for the device
   always_comb begin
      w_in_next = r_in_state;
      w_in_load = 1'b0;
      w_in_data = '0;
      w_in_err  = 1'b0;
      w_consume = '0;
      w_bypass  = '0;
      case (r_in_state)
         IO_IDLE: begin
            if (!in_req) begin
               w_in_next = IO_IDLE;
            end else if (!w_in_range) begin
               w_in_next = IO_DONE;
               w_in_load = 1'b1;
               w_in_err  = 1'b1;
            end else if (pending[w_dev]) begin
               w_in_next          = IO_DONE;
               w_in_load          = 1'b1;
               w_in_data          = w_slot_dout[w_dev];
               w_consume[w_dev]   = 1'b1;
            end else if (enter_in[w_dev]) begin
               w_in_next          = IO_DONE;
               w_in_load          = 1'b1;
               w_in_data          = dev_in[w_dev*DATA_W +: DATA_W];
               w_bypass[w_dev]    = 1'b1;
            end else begin
               w_in_next = IO_WAIT;
            end
         end
         IO_WAIT: begin
            if (enter_in[r_in_dev]) begin
               w_in_next          = IO_DONE;
               w_in_load          = 1'b1;
               w_in_data          = dev_in[r_in_dev*DATA_W +: DATA_W];
               w_bypass[r_in_dev] = 1'b1;
            end else begin
               w_in_next = IO_WAIT;
            end
         end
         IO_DONE: begin
            if (!in_req) begin
               w_in_next = IO_IDLE;
            end else begin
               w_in_next = IO_DONE;
            end
         end
         default: w_in_next = IO_IDLE;
      endcase
   end

   // Output FSM next state: offer the word, wait for the device to accept it
   always_comb begin
      w_out_next  = r_out_state;
      w_out_start = 1'b0;
      w_out_err   = 1'b0;
      case (r_out_state)
         IO_IDLE: begin
            if (!new_out) begin
               w_out_next = IO_IDLE;
            end else if (w_in_range) begin
               w_out_next  = IO_SEND;
               w_out_start = 1'b1;
            end else begin
               w_out_next = IO_DONE;
               w_out_err  = 1'b1;
            end
         end
         IO_SEND: begin
            if (done_out[r_out_dev]) begin
               w_out_next = IO_DONE;
            end else begin
               w_out_next = IO_SEND;
            end
         end
         IO_DONE: begin
            if (!new_out) begin
               w_out_next = IO_IDLE;
            end else begin
               w_out_next = IO_DONE;
            end
         end
         default: w_out_next = IO_IDLE;
      endcase
   end

   // Datapath registers: device latch on leaving idle, returned word, output words, error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_dev    <= '0;
         r_out_dev   <= '0;
         r_e_data    <= '0;
         r_dev_out   <= '0;
         r_enter_out <= '0;
         r_addr_err  <= 1'b0;
      end else begin
         if (r_in_state == IO_IDLE) begin
            r_in_dev <= w_dev;
         end
         if (w_in_load) begin
            r_e_data <= w_in_data;
         end
         if (w_out_start) begin
            r_out_dev                           <= w_dev;
            r_dev_out[w_dev*DATA_W +: DATA_W]   <= p_data;
            r_enter_out                         <= f_onehot(w_dev);
         end else if (w_out_next != IO_SEND) begin
            r_enter_out <= '0;
         end
         r_addr_err <= r_addr_err | w_in_err | w_out_err;
      end
   end

   // Handshake outputs decoded from the FSM states
   always_comb begin
      in_ready  = (r_in_state == IO_DONE);
      out_ready = (r_out_state == IO_DONE);
   end

   assign e_data       = r_e_data;
   assign dev_out      = r_dev_out;
   assign enter_out    = r_enter_out;
   assign addr_err     = r_addr_err;
   assign input_state  = r_in_state;
   assign output_state = r_out_state;

endmodule

// File: tb/tb_io_port_hub.sv
// Self-checking bench for io_port_hub (4 devices x 32 bits): directed
// scenarios plus randomized IN/OUT transactions against a slot-level model.
module tb_io_port_hub;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [9:0]   adress = '0;
   logic [31:0]  p_data = '0;
   logic         in_req = 1'b0;
   logic         new_out = 1'b0;
   logic [31:0]  e_data;
   logic         in_ready, out_ready;
   logic [127:0] dev_in = '0;
   logic [3:0]   enter_in = '0;
   logic [127:0] dev_out;
   logic [3:0]   enter_out;
   logic [3:0]   done_out = '0;
   logic [3:0]   pending, overrun;
   logic         addr_err;
   logic [1:0]   input_state, output_state;

   io_port_hub #(.NUM_DEV(4), .DATA_W(32), .ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .adress(adress), .p_data(p_data),
      .in_req(in_req), .new_out(new_out), .e_data(e_data),
      .in_ready(in_ready), .out_ready(out_ready), .dev_in(dev_in),
      .enter_in(enter_in), .dev_out(dev_out), .enter_out(enter_out),
      .done_out(done_out), .pending(pending), .overrun(overrun),
      .addr_err(addr_err), .input_state(input_state), .output_state(output_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: slot contents, device words, output words, sticky error
   logic [31:0] m_hold [4];
   logic [31:0] m_din  [4];
   logic [31:0] m_dout [4];
   logic [3:0]  m_pend, m_ovr;
   logic        m_err;

   function automatic logic [127:0] m_dout_vec();
      return {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 4; d++) begin
         m_hold[d] = '0; m_dout[d] = '0;
      end
      m_pend = '0; m_ovr = '0; m_err = 1'b0;
   endtask

   // Apply the slot rules for one clock: cons = device read from its slot, byp = strobe taken directly
   task automatic model_slots(input int cons, input int byp);
      for (int d = 0; d < 4; d++) begin
         if (enter_in[d] && d != byp) begin
            if (d == cons) m_ovr[d] = 1'b0;
            else if (m_pend[d]) m_ovr[d] = 1'b1;
            m_hold[d] = m_din[d];
            m_pend[d] = 1'b1;
         end else if (d == cons) begin
            m_pend[d] = 1'b0;
            m_ovr[d]  = 1'b0;
         end
      end
   endtask

   task automatic clk_edge(input int cons, input int byp);
      dev_in = {m_din[3], m_din[2], m_din[1], m_din[0]};
      model_slots(cons, byp);
      @(posedge clk); #1;
      enter_in = '0;
   endtask

   task automatic rand_strobe(input logic [3:0] mask);
      for (int d = 0; d < 4; d++) m_din[d] = $urandom;
      enter_in = 4'($urandom) & mask;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 4; d++) m_din[d] = '0;
      model_clear();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      n_cmp++;
      if ({e_data, in_ready, out_ready, enter_out, pending, overrun, addr_err, input_state, output_state} !== 53'd0) begin
         n_fail++; $display("FAIL reset_outputs: got e=%h ir=%b or=%b eo=%b p=%b o=%b ae=%b is=%0d os=%0d want all 0",
                            e_data, in_ready, out_ready, enter_out, pending, overrun, addr_err, input_state, output_state);
      end
      n_cmp++;
      if (dev_out !== 128'd0) begin n_fail++; $display("FAIL reset_dev_out: got %h want 0", dev_out); end
   endtask

   task automatic test_early_arrival();
      m_din[2] = 32'hCAFE0002; enter_in = 4'b0100;
      clk_edge(-1, -1);
      n_cmp++;
      if (pending !== 4'b0100) begin n_fail++; $display("FAIL early_pending: got %b want 0100", pending); end
      repeat (4) clk_edge(-1, -1);
      adress = 10'd2; in_req = 1'b1;
      clk_edge(2, -1);
      n_cmp++;
      if (in_ready !== 1'b1 || e_data !== 32'hCAFE0002) begin
         n_fail++; $display("FAIL early_read: got ir=%b e=%h want ir=1 e=cafe0002", in_ready, e_data);
      end
      n_cmp++;
      if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL early_consumed: got %b want 0", pending[2]); end
      in_req = 1'b0;
      clk_edge(-1, -1);
      n_cmp++;
      if (in_ready !== 1'b0 || input_state !== 2'd0) begin
         n_fail++; $display("FAIL early_release: got ir=%b st=%0d want 0 0", in_ready, input_state);
      end
   endtask

   task automatic test_wait_path();
      adress = 10'd1; in_req = 1'b1;
      clk_edge(-1, -1);
      n_cmp++;
      if (input_state !== 2'd1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL wait_state: got st=%0d ir=%b want 1 0", input_state, in_ready);
      end
      adress = 10'd0;
      clk_edge(-1, -1);
      m_din[1] = 32'h11; enter_in = 4'b0010;
      clk_edge(-1, 1);
      n_cmp++;
      if (in_ready !== 1'b1 || e_data !== 32'h11 || pending[1] !== 1'b0) begin
         n_fail++; $display("FAIL wait_read: got ir=%b e=%h p1=%b want 1 00000011 0", in_ready, e_data, pending[1]);
      end
      in_req = 1'b0;
      clk_edge(-1, -1);
   endtask

   task automatic test_overrun();
      m_din[0] = 32'hA; enter_in = 4'b0001; clk_edge(-1, -1);
      m_din[0] = 32'hB; enter_in = 4'b0001; clk_edge(-1, -1);
      n_cmp++;
      if (overrun[0] !== 1'b1 || pending[0] !== 1'b1) begin
         n_fail++; $display("FAIL overrun_set: got o=%b p=%b want 1 1", overrun[0], pending[0]);
      end
      adress = 10'd0; in_req = 1'b1;
      clk_edge(0, -1);
      n_cmp++;
      if (e_data !== 32'hB || overrun[0] !== 1'b0 || pending[0] !== 1'b0) begin
         n_fail++; $display("FAIL overrun_read: got e=%h o=%b p=%b want 0000000b 0 0", e_data, overrun[0], pending[0]);
      end
      in_req = 1'b0;
      clk_edge(-1, -1);
   endtask

   task automatic test_output();
      adress = 10'd3; p_data = 32'h5A5A; new_out = 1'b1;
      m_dout[3] = 32'h5A5A;
      clk_edge(-1, -1);
      n_cmp++;
      if (enter_out !== 4'b1000 || dev_out[127:96] !== 32'h5A5A || output_state !== 2'd1) begin
         n_fail++; $display("FAIL out_offer: got eo=%b w=%h st=%0d want 1000 00005a5a 1", enter_out, dev_out[127:96], output_state);
      end
      adress = 10'd1; p_data = 32'hDEAD;
      repeat (3) clk_edge(-1, -1);
      n_cmp++;
      if (enter_out !== 4'b1000 || dev_out !== m_dout_vec() || out_ready !== 1'b0) begin
         n_fail++; $display("FAIL out_hold: got eo=%b dev_out=%h or=%b want 1000 %h 0", enter_out, dev_out, out_ready, m_dout_vec());
      end
      done_out = 4'b1000;
      clk_edge(-1, -1);
      done_out = 4'b0000;
      n_cmp++;
      if (out_ready !== 1'b1 || enter_out !== 4'b0000 || output_state !== 2'd2) begin
         n_fail++; $display("FAIL out_done: got or=%b eo=%b st=%0d want 1 0000 2", out_ready, enter_out, output_state);
      end
      new_out = 1'b0;
      clk_edge(-1, -1);
      n_cmp++;
      if (out_ready !== 1'b0 || output_state !== 2'd0 || addr_err !== 1'b0) begin
         n_fail++; $display("FAIL out_release: got or=%b st=%0d ae=%b want 0 0 0", out_ready, output_state, addr_err);
      end
   endtask

   task automatic test_out_of_range();
      adress = 10'd7; in_req = 1'b1; m_err = 1'b1;
      clk_edge(-1, -1);
      n_cmp++;
      if (in_ready !== 1'b1 || e_data !== 32'd0 || addr_err !== 1'b1) begin
         n_fail++; $display("FAIL oor_in: got ir=%b e=%h ae=%b want 1 0 1", in_ready, e_data, addr_err);
      end
      in_req = 1'b0;
      clk_edge(-1, -1);
      new_out = 1'b1; p_data = 32'h1234;
      clk_edge(-1, -1);
      n_cmp++;
      if (enter_out !== 4'b0000 || out_ready !== 1'b1 || addr_err !== 1'b1 || dev_out !== m_dout_vec()) begin
         n_fail++; $display("FAIL oor_out: got eo=%b or=%b ae=%b want 0000 1 1", enter_out, out_ready, addr_err);
      end
      new_out = 1'b0;
      clk_edge(-1, -1);
   endtask

   task automatic test_reset_mid_send();
      adress = 10'd1; p_data = $urandom; new_out = 1'b1;
      m_dout[1] = p_data;
      clk_edge(-1, -1);
      adress = 10'd3; in_req = 1'b1;
      m_din[0] = 32'h77; enter_in = 4'b0001;
      clk_edge(-1, -1);
      n_cmp++;
      if (enter_out !== 4'b0010 || input_state !== 2'd1 || pending[0] !== 1'b1) begin
         n_fail++; $display("FAIL rst_setup: got eo=%b is=%0d p=%b want 0010 1 xxx1", enter_out, input_state, pending);
      end
      reset = 1'b1; enter_in = 4'b0100;
      @(posedge clk); #1;
      enter_in = '0;
      model_clear();
      n_cmp++;
      if (enter_out !== 4'b0 || input_state !== 2'd0 || output_state !== 2'd0 || pending !== 4'b0 ||
          overrun !== 4'b0 || dev_out !== 128'd0 || addr_err !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_abort: got eo=%b is=%0d os=%0d p=%b o=%b ae=%b want all 0",
                            enter_out, input_state, output_state, pending, overrun, addr_err);
      end
      reset = 1'b0; in_req = 1'b0; new_out = 1'b0;
      clk_edge(-1, -1);
      n_cmp++;
      if (pending !== 4'b0 || output_state !== 2'd0) begin
         n_fail++; $display("FAIL rst_strobe_dropped: got p=%b os=%0d want 0000 0", pending, output_state);
      end
   endtask

   task automatic test_random_in();
      logic [9:0]  a;
      logic [31:0] exp;
      int          d;
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 3)) begin
            rand_strobe(4'hF);
            clk_edge(-1, -1);
         end
         n_cmp++;
         if (pending !== m_pend || overrun !== m_ovr) begin
            n_fail++; $display("FAIL rin_slots it%0d: got p=%b o=%b want %b %b", it, pending, overrun, m_pend, m_ovr);
         end
         a = ($urandom_range(0, 3) == 0) ? (10'($urandom) | 10'h004) : 10'($urandom_range(0, 3));
         adress = a; in_req = 1'b1;
         rand_strobe(4'hF);
         d = int'(a[1:0]);
         if (a >= 10'd4) begin
            exp = 32'd0; m_err = 1'b1;
            clk_edge(-1, -1);
         end else if (m_pend[d]) begin
            exp = m_hold[d];
            clk_edge(d, -1);
         end else if (enter_in[d]) begin
            exp = m_din[d];
            clk_edge(-1, d);
         end else begin
            clk_edge(-1, -1);
            n_cmp++;
            if (input_state !== 2'd1) begin
               n_fail++; $display("FAIL rin_wait it%0d: got st=%0d want 1", it, input_state);
            end
            repeat ($urandom_range(0, 3)) begin
               adress = 10'($urandom);
               rand_strobe(~(4'b0001 << d));
               clk_edge(-1, -1);
            end
            adress = 10'($urandom);
            rand_strobe(4'hF);
            enter_in[d] = 1'b1;
            exp = m_din[d];
            clk_edge(-1, d);
         end
         n_cmp++;
         if (in_ready !== 1'b1 || e_data !== exp || pending !== m_pend || overrun !== m_ovr || addr_err !== m_err) begin
            n_fail++; $display("FAIL rin_done it%0d: got ir=%b e=%h p=%b o=%b ae=%b want 1 %h %b %b %b",
                               it, in_ready, e_data, pending, overrun, addr_err, exp, m_pend, m_ovr, m_err);
         end
         repeat ($urandom_range(0, 2)) begin
            adress = 10'($urandom);
            rand_strobe(4'hF);
            clk_edge(-1, -1);
         end
         n_cmp++;
         if (in_ready !== 1'b1 || e_data !== exp) begin
            n_fail++; $display("FAIL rin_stable it%0d: got ir=%b e=%h want 1 %h", it, in_ready, e_data, exp);
         end
         in_req = 1'b0;
         rand_strobe(4'hF);
         clk_edge(-1, -1);
         n_cmp++;
         if (in_ready !== 1'b0 || input_state !== 2'd0 || pending !== m_pend || overrun !== m_ovr) begin
            n_fail++; $display("FAIL rin_release it%0d: got ir=%b st=%0d p=%b o=%b want 0 0 %b %b",
                               it, in_ready, input_state, pending, overrun, m_pend, m_ovr);
         end
      end
   endtask

   task automatic test_random_out();
      logic [9:0] a;
      int         d;
      for (int it = 0; it < 20; it++) begin
         a = ($urandom_range(0, 3) == 0) ? (10'($urandom) | 10'h004) : 10'($urandom_range(0, 3));
         d = int'(a[1:0]);
         adress = a; p_data = $urandom; new_out = 1'b1;
         if (a < 10'd4) m_dout[d] = p_data;
         else m_err = 1'b1;
         clk_edge(-1, -1);
         if (a < 10'd4) begin
            n_cmp++;
            if (enter_out !== (4'b0001 << d) || dev_out !== m_dout_vec() || out_ready !== 1'b0) begin
               n_fail++; $display("FAIL rout_offer it%0d: got eo=%b dev_out=%h or=%b want %b %h 0",
                                  it, enter_out, dev_out, out_ready, 4'b0001 << d, m_dout_vec());
            end
            repeat ($urandom_range(0, 3)) begin
               adress = 10'($urandom); p_data = $urandom;
               done_out = 4'($urandom) & ~(4'b0001 << d);
               clk_edge(-1, -1);
            end
            done_out = 4'b0001 << d;
            clk_edge(-1, -1);
            done_out = '0;
         end
         n_cmp++;
         if (enter_out !== 4'b0 || out_ready !== 1'b1 || dev_out !== m_dout_vec() || addr_err !== m_err) begin
            n_fail++; $display("FAIL rout_done it%0d: got eo=%b or=%b ae=%b dev_out=%h want 0000 1 %b %h",
                               it, enter_out, out_ready, addr_err, dev_out, m_err, m_dout_vec());
         end
         new_out = 1'b0;
         clk_edge(-1, -1);
         n_cmp++;
         if (out_ready !== 1'b0 || output_state !== 2'd0) begin
            n_fail++; $display("FAIL rout_release it%0d: got or=%b st=%0d want 0 0", it, out_ready, output_state);
         end
      end
   endtask

   initial begin
      test_reset();
      test_early_arrival();
      test_wait_path();
      test_overrun();
      test_output();
      test_out_of_range();
      test_reset_mid_send();
      test_random_in();
      test_random_out();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
